// File: rtl/i2s_dac_transmitter.sv
// I2S (Philips) transmitter: buffers 16-bit samples in a small FIFO and
// serializes each one MSB first into both the left and right slots of a frame.
module i2s_dac_transmitter #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          BCLK_out,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [SAMPLE_W-1:0]           in_data,
  output logic                          in_ready,
  output logic                          DAC_BCLK,
  output logic                          DAC_LRCLK,
  output logic                          DAC_DIN,
  output logic                          frame_start,
  output logic                          underflow,
  output logic [7:0]                    underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam int P_W   = CNT_W - 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [7:0]          ucnt_q, ucnt_d;
  logic                lr_q, lr_d, din_q, din_d, fs_q, fs_d, uf_q, uf_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

  logic                wrap, push, pop;
  logic [P_W-1:0]      p_d;
  logic [SAMPLE_W-1:0] shifted;

  always_comb begin
    in_ready = reset && (lvl_q < DEPTH_L);
    push     = in_valid && in_ready;
    wrap     = (cnt_q == {CNT_W{1'b1}});
    // Emptiness is taken from the registered level, so a push on the wrap
    // cycle still counts as an underflow and is held for the next frame.
    pop      = wrap && (lvl_q != '0);

    cnt_d = cnt_q + 1'b1;
    cur_d = cur_q;
    if (wrap) cur_d = pop ? mem_q[rd_q] : '0;

    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop  ? rd_q + 1'b1 : rd_q;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase

    fs_d   = wrap;
    uf_d   = wrap && (lvl_q == '0);
    ucnt_d = (uf_d && (ucnt_q != 8'hFF)) ? ucnt_q + 1'b1 : ucnt_q;

    // Outputs are computed from next-cycle state so they line up with cnt.
    // Slot bit 0 is the one-bit I2S delay; bits 1..SAMPLE_W carry MSB..LSB.
    lr_d    = cnt_d[CNT_W-1];
    p_d     = cnt_d[P_W-1:0];
    shifted = cur_d << (p_d - 1'b1);
    din_d   = 1'b0;
    if ((p_d != '0) && (p_d <= P_W'(SAMPLE_W))) din_d = shifted[SAMPLE_W-1];
  end

  always_ff @(posedge BCLK_out) begin
    if (!reset) begin
      cnt_q  <= '0;
      cur_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ucnt_q <= '0;
      lr_q   <= 1'b0;
      din_q  <= 1'b0;
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      ucnt_q <= ucnt_d;
      lr_q   <= lr_d;
      din_q  <= din_d;
      fs_q   <= fs_d;
      uf_q   <= uf_d;
    end
  end

  always_ff @(posedge BCLK_out) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  assign DAC_BCLK      = reset & ~BCLK_out;
  assign DAC_LRCLK     = lr_q;
  assign DAC_DIN       = din_q;
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;
  assign fifo_level    = lvl_q;

endmodule

// File: doc/i2s_dac_transmitter.md
# i2s_dac_transmitter

Transmit-side counterpart to the I2S microphone capture path. The block accepts 16-bit signed audio samples through a valid/ready handshake and buffers them in a small FIFO. It serializes each sample, MSB first, onto an I2S (Philips format) link to an external DAC/amplifier, duplicating every sample into the left and right slots. It sits between the audio processing or playback logic and the DAC pins, and runs entirely on the BCLK-rate clock.

## Interface
- SAMPLE_W, 16: sample width in bits, two's complement.
- SLOT_W, 32: BCLK cycles per channel slot; frame = 2*SLOT_W = 64 cycles.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two, 2 or more.
- BCLK_out  in  1  block clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has a sample on in_data.
- in_data  in  SAMPLE_W  sample to transmit.
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid && in_ready at a rising edge.
- DAC_BCLK  out  1  bit clock to DAC = ~BCLK_out when reset high, held 0 while reset low.
- DAC_LRCLK  out  1  word select: 0 = left slot, 1 = right slot.
- DAC_DIN  out  1  serial data to DAC.
- frame_start  out  1  one-cycle pulse on the first cycle of each new frame.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- underflow_cnt  out  8  saturating count of underflow events.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Frame counter cnt (6 bits) increments every cycle, 0..63, then wraps to 0.
- For a cycle with counter value c, p = c mod 32:
  - DAC_LRCLK = (c >= 32).
  - DAC_DIN = cur_sample[SAMPLE_W-p] for p = 1..16.
  - DAC_DIN = 0 for p = 0 and p = 17..31. This gives the I2S one-bit delay after each LRCLK edge.
- Left and right slots carry the same cur_sample.
- Frame load happens at the edge where cnt goes 63 → 0:
  - FIFO non-empty: pop the head into cur_sample, pulse frame_start.
  - FIFO empty: load cur_sample = 0, pulse frame_start and underflow, increment underflow_cnt (saturate at 255).
- Empty is judged on registered state. A push in the same cycle as a load at empty still counts as underflow, and the pushed sample is kept for the next frame.
- FIFO behaviour:
  - in_ready = reset && (fifo_level < FIFO_DEPTH).
  - A push and a pop in the same cycle (non-empty, non-full) leave fifo_level unchanged.
  - No push is possible when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (reset low at a rising edge):
  - cnt = 0, cur_sample = 0, FIFO emptied, fifo_level = 0, underflow_cnt = 0.
  - DAC_LRCLK = 0, DAC_DIN = 0, frame_start = 0, underflow = 0.
  - in_ready = 0 and DAC_BCLK = 0 while reset is low.
- Reset mid-frame aborts the frame immediately; queued samples are discarded.
- The first frame after reset release transmits cur_sample = 0 with no frame_start or underflow pulse. The first load occurs at the first 63 → 0 wrap.

## Timing
- All outputs are registered; their values follow the cnt-based definition with zero skew relative to cnt.
- The DAC samples DAC_DIN on the DAC_BCLK rising edge, which is the BCLK_out falling edge (mid-bit).
- First edge with reset high: cnt leaves 0 → 1. The first frame's cnt = 63 cycle is the 64th cycle after release.
- Push-to-output latency:
  - A sample pushed into an empty FIFO before the wrap edge appears as MSB at cnt = 1 of the next frame.
  - Worst case is 65 + 64*(fifo_level before push) cycles.
- Sustained throughput: one sample per 64 cycles (3 MHz BCLK → ~46.9 kHz frames).
- frame_start and underflow are high for exactly the cycle with cnt = 0.

## Test plan
- Reset values: hold reset low 5 cycles, then check:
  - all outputs 0, in_ready = 0, DAC_BCLK = 0, fifo_level = 0.
  - after release, in_ready = 1 and the first 64 cycles have DAC_DIN = 0 with LRCLK low for 32 cycles, then high for 32.
- Single sample: push 0xA5C3 during the first frame, then check the next frame:
  - DAC_DIN at cnt 1..16 = 1010010111000011.
  - the same 16 bits repeat at cnt 33..48; all other cycles are 0.
  - frame_start pulses at cnt = 0.
- FIFO full: push 4 samples back-to-back.
  - fifo_level = 4 and in_ready = 0; a 5th in_valid is not accepted.
  - at the next wrap, fifo_level = 3 and in_ready = 1.
  - the 4 samples are transmitted in order over 4 frames.
- Underflow: let the FIFO run empty for 3 frames.
  - 3 underflow pulses, underflow_cnt = 3, DAC_DIN all 0 in those frames.
  - force 300 underflows: underflow_cnt = 255.
- Simultaneous events:
  - push at the cnt = 63 cycle with an empty FIFO: underflow pulses, fifo_level = 1, the sample is sent in the following frame.
  - push and pop in the same cycle at fifo_level = 2: fifo_level stays 2.
- Reset mid-frame: reset low at cnt = 20 with 3 samples queued.
  - outputs and fifo_level return to reset values; underflow_cnt = 0.
  - no queued sample is transmitted after release.
